decode_hazard_ctrl: RTL

Decode-stage consumer of the forwarding unit's per-stage forwardable destination addresses. For each decode-stage source register it picks an operand source: register file or the E/M/W forward data. When a source depends on an in-flight writer that cannot forward, it stalls fetch/decode and inserts bubbles into E. Operand selects and valid are registered into the D/E pipeline register. E then uses them to choose among regfile data and DE_E/M/W forward data.

---
 rtl/decode_hazard_ctrl_pkg.sv | 19 +
 rtl/decode_hazard_ctrl_operand_resolve.sv | 52 +++++
 rtl/decode_hazard_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/decode_hazard_ctrl_pkg.sv
// decode_hazard_ctrl_pkg: shared types and constants for the decode hazard controller.
//   fwd_sel_e      - operand source select (regfile or E/M/W forward path)
//   hazard_state_e - RUN / STALL controller state
//   ZERO_REG       - architectural zero register, never a dependency
package decode_hazard_ctrl_pkg;
    typedef enum logic [1:0] {
        SEL_REG = 2'd0,
        SEL_E   = 2'd1,
        SEL_M   = 2'd2,
        SEL_W   = 2'd3
    } fwd_sel_e;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } hazard_state_e;

    localparam logic [4:0] ZERO_REG = 5'd0;
endpackage

// File: rtl/decode_hazard_ctrl_operand_resolve.sv
// operand_resolve: combinational operand-source resolver for one decode source register.
// Ports:
//   i_rs, i_use                       - source register and whether it is read
//   i_{e,m,w}_w_enable/_rd/_fwd       - per-stage write enable, destination, forwardable destination
//   o_sel                             - chosen operand source
//   o_hazard                          - youngest matching writer cannot forward yet
module operand_resolve
    import decode_hazard_ctrl_pkg::*;
(
    input  logic [4:0] i_rs,
    input  logic       i_use,
    input  logic       i_e_w_enable,
    input  logic [4:0] i_e_rd,
    input  logic [4:0] i_e_fwd,
    input  logic       i_m_w_enable,
    input  logic [4:0] i_m_rd,
    input  logic [4:0] i_m_fwd,
    input  logic       i_w_w_enable,
    input  logic [4:0] i_w_rd,
    input  logic [4:0] i_w_fwd,
    output fwd_sel_e   o_sel,
    output logic       o_hazard
);
    logic w_active;
    logic w_e_hit;
    logic w_m_hit;
    logic w_w_hit;

    assign w_active = i_use && (i_rs != ZERO_REG);
    assign w_e_hit  = i_e_w_enable && (i_e_rd == i_rs);
    assign w_m_hit  = i_m_w_enable && (i_m_rd == i_rs);
    assign w_w_hit  = i_w_w_enable && (i_w_rd == i_rs);

    // Only the youngest matching writer counts; an older stage is never consulted
    // once a younger one matches, even if the older one could forward.
    always_comb begin
        o_sel    = SEL_REG;
        o_hazard = 1'b0;
        if (w_active) begin
            if (w_e_hit) begin
                o_sel    = (i_e_fwd == i_rs) ? SEL_E : SEL_REG;
                o_hazard = (i_e_fwd != i_rs);
            end else if (w_m_hit) begin
                o_sel    = (i_m_fwd == i_rs) ? SEL_M : SEL_REG;
                o_hazard = (i_m_fwd != i_rs);
            end else if (w_w_hit) begin
                o_sel    = (i_w_fwd == i_rs) ? SEL_W : SEL_REG;
                o_hazard = (i_w_fwd != i_rs);
            end
        end
    end
endmodule

// File: rtl/decode_hazard_ctrl.sv
// decode_hazard_ctrl: decode-stage operand select, stall and bubble control feeding the D/E register.
// Ports:
//   clk, rstd (sync active-low reset)
//   i_d_valid, i_d_rs1_addr, i_d_rs2_addr, i_d_use_rs1, i_d_use_rs2 - decode instruction sources
//   i_{e,m,w}_w_enable, i_{e,m,w}_rd_addr, i_{e,m,w}_forwardable_addr  - in-flight writers
//   i_e_flush            - redirect; kills decode and any bubble in progress
//   o_d_stall            - hold PC and F/D (combinational)
//   o_de_valid, o_de_rs1_sel, o_de_rs2_sel - registered D/E control
//   o_hazard_timeout     - sticky stall watchdog
// Optional (HAZARD_PERF_CNT_EN): o_perf_stall_cnt, o_perf_fwd_cnt.
module decode_hazard_ctrl
    import decode_hazard_ctrl_pkg::*;
#(
    parameter int MAX_STALL_CYCLES = 8,
    parameter int STALL_CNT_W      = 4
)
(
    input  logic       clk,
    input  logic       rstd,
    input  logic       i_d_valid,
    input  logic [4:0] i_d_rs1_addr,
    input  logic [4:0] i_d_rs2_addr,
    input  logic       i_d_use_rs1,
    input  logic       i_d_use_rs2,
    input  logic       i_e_w_enable,
    input  logic       i_m_w_enable,
    input  logic       i_w_w_enable,
    input  logic [4:0] i_e_rd_addr,
    input  logic [4:0] i_m_rd_addr,
    input  logic [4:0] i_w_rd_addr,
    input  logic [4:0] i_e_forwardable_addr,
    input  logic [4:0] i_m_forwardable_addr,
    input  logic [4:0] i_w_forwardable_addr,
    input  logic       i_e_flush,
    output logic       o_d_stall,
    output logic       o_de_valid,
    output logic [1:0] o_de_rs1_sel,
    output logic [1:0] o_de_rs2_sel,
    output logic       o_hazard_timeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] o_perf_stall_cnt,
    output logic [31:0] o_perf_fwd_cnt
`endif
);
    localparam logic [STALL_CNT_W-1:0] MAX_CNT = STALL_CNT_W'(MAX_STALL_CYCLES);

    fwd_sel_e              w_sel1;
    fwd_sel_e              w_sel2;
    logic                  w_haz1;
    logic                  w_haz2;
    logic                  w_d_stall;
    logic [STALL_CNT_W-1:0] w_cnt_inc;
    hazard_state_e         w_state_nxt;

    hazard_state_e         r_state;
    logic                  r_de_valid;
    fwd_sel_e              r_de_rs1_sel;
    fwd_sel_e              r_de_rs2_sel;
    logic [STALL_CNT_W-1:0] r_cnt;
    logic                  r_timeout;

    operand_resolve u_rs1 (
        .i_rs(i_d_rs1_addr), .i_use(i_d_use_rs1),
        .i_e_w_enable(i_e_w_enable), .i_e_rd(i_e_rd_addr), .i_e_fwd(i_e_forwardable_addr),
        .i_m_w_enable(i_m_w_enable), .i_m_rd(i_m_rd_addr), .i_m_fwd(i_m_forwardable_addr),
        .i_w_w_enable(i_w_w_enable), .i_w_rd(i_w_rd_addr), .i_w_fwd(i_w_forwardable_addr),
        .o_sel(w_sel1), .o_hazard(w_haz1)
    );

    operand_resolve u_rs2 (
        .i_rs(i_d_rs2_addr), .i_use(i_d_use_rs2),
        .i_e_w_enable(i_e_w_enable), .i_e_rd(i_e_rd_addr), .i_e_fwd(i_e_forwardable_addr),
        .i_m_w_enable(i_m_w_enable), .i_m_rd(i_m_rd_addr), .i_m_fwd(i_m_forwardable_addr),
        .i_w_w_enable(i_w_w_enable), .i_w_rd(i_w_rd_addr), .i_w_fwd(i_w_forwardable_addr),
        .o_sel(w_sel2), .o_hazard(w_haz2)
    );

    // A flush kills the dependent instruction, so it must never also stall.
    assign w_d_stall = i_d_valid && (w_haz1 || w_haz2) && !i_e_flush && rstd;
    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN:     w_state_nxt = w_d_stall ? STALL : RUN;
            STALL:   w_state_nxt = w_d_stall ? STALL : RUN;
            default: w_state_nxt = RUN;
        endcase
        if (i_e_flush) w_state_nxt = RUN;
    end

    always_ff @(posedge clk) begin
        if (!rstd) begin
            r_state      <= RUN;
            r_de_valid   <= 1'b0;
            r_de_rs1_sel <= SEL_REG;
            r_de_rs2_sel <= SEL_REG;
            r_cnt        <= '0;
            r_timeout    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (i_e_flush) begin
                r_de_valid   <= 1'b0;
                r_de_rs1_sel <= SEL_REG;
                r_de_rs2_sel <= SEL_REG;
                r_cnt        <= '0;
            end else if (w_d_stall) begin
                r_de_valid   <= 1'b0;
                r_de_rs1_sel <= SEL_REG;
                r_de_rs2_sel <= SEL_REG;
                r_cnt        <= w_cnt_inc;
                if (w_cnt_inc >= MAX_CNT) r_timeout <= 1'b1;
            end else begin
                r_de_valid   <= i_d_valid;
                r_de_rs1_sel <= w_sel1;
                r_de_rs2_sel <= w_sel2;
                r_cnt        <= '0;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_fwd;
    logic [31:0] w_fwd_inc;

    assign w_fwd_inc = 32'(w_sel1 != SEL_REG) + 32'(w_sel2 != SEL_REG);

    always_ff @(posedge clk) begin
        if (!rstd) begin
            r_perf_stall <= '0;
            r_perf_fwd   <= '0;
        end else begin
            if (w_d_stall) r_perf_stall <= r_perf_stall + 32'd1;
            if (!i_e_flush && !w_d_stall && i_d_valid) r_perf_fwd <= r_perf_fwd + w_fwd_inc;
        end
    end

    assign o_perf_stall_cnt = r_perf_stall;
    assign o_perf_fwd_cnt   = r_perf_fwd;
`endif

    assign o_d_stall        = w_d_stall;
    assign o_de_valid       = r_de_valid;
    assign o_de_rs1_sel     = r_de_rs1_sel;
    assign o_de_rs2_sel     = r_de_rs2_sel;
    assign o_hazard_timeout = r_timeout;
endmodule
